// File: rtl/hazard_ctrl_if.sv
// Decode-to-hazard-unit bundle: the D-stage Tuse/Tnew/address tuple going in,
// and the stall request, forwarding selects and stall counter coming back.
interface hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [1:0]       tuse_rs_d;
  logic [1:0]       tuse_rt_d;
  logic [1:0]       tnew_d;
  logic [4:0]       a_rs_d;
  logic [4:0]       a_rt_d;
  logic [4:0]       a_write_d;
  logic             stall;
  logic [1:0]       fwd_rs_d;
  logic [1:0]       fwd_rt_d;
  logic [1:0]       fwd_rs_e;
  logic [1:0]       fwd_rt_e;
  logic             fwd_rt_m;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output tuse_rs_d, tuse_rt_d, tnew_d, a_rs_d, a_rt_d, a_write_d,
    input  stall, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m, stall_cnt
  );

  modport slave (
    input  tuse_rs_d, tuse_rt_d, tnew_d, a_rs_d, a_rt_d, a_write_d,
    output stall, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m, stall_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Stall/forward scheduler for the 5-stage MIPS pipeline: shadows the decode
// Tuse/Tnew tuple down E/M/W and derives stall plus every forwarding select.
module hazard_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic        clk,
  input  logic        reset_n,
  hazard_ctrl_if.slave hz
);

  logic [4:0]       a_rs_e_q, a_rs_e_d;
  logic [4:0]       a_rt_e_q, a_rt_e_d;
  logic [4:0]       a_write_e_q, a_write_e_d;
  logic [1:0]       tnew_e_q, tnew_e_d;
  logic [4:0]       a_rt_m_q, a_rt_m_d;
  logic [4:0]       a_write_m_q, a_write_m_d;
  logic [1:0]       tnew_m_q, tnew_m_d;
  logic [4:0]       a_write_w_q, a_write_w_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             stall;

  function automatic logic [1:0] sat0(input logic [1:0] x);
    return (x == 2'd0) ? 2'd0 : x - 2'd1;
  endfunction

  function automatic logic need_stall(input logic [1:0] tuse, input logic [4:0] addr,
                                      input logic [4:0] aw_e, input logic [1:0] tn_e,
                                      input logic [4:0] aw_m, input logic [1:0] tn_m);
    return (tuse != 2'd3) && (addr != 5'd0) &&
           (((addr == aw_e) && (tn_e > tuse)) || ((addr == aw_m) && (tn_m > tuse)));
  endfunction

  // The youngest matching stage decides; if its result is not ready yet,
  // older stages must not be consulted or stale data would be forwarded.
  function automatic logic [1:0] sel_d(input logic [4:0] addr,
                                       input logic [4:0] aw_e, input logic [1:0] tn_e,
                                       input logic [4:0] aw_m, input logic [1:0] tn_m,
                                       input logic [4:0] aw_w);
    logic [1:0] sel;
    sel = 2'd0;
    if (addr == 5'd0)      sel = 2'd0;
    else if (addr == aw_e) sel = (tn_e == 2'd0) ? 2'd1 : 2'd0;
    else if (addr == aw_m) sel = (tn_m == 2'd0) ? 2'd2 : 2'd0;
    else if (addr == aw_w) sel = 2'd3;
    return sel;
  endfunction

  function automatic logic [1:0] sel_e(input logic [4:0] addr,
                                       input logic [4:0] aw_m, input logic [1:0] tn_m,
                                       input logic [4:0] aw_w);
    logic [1:0] sel;
    sel = 2'd0;
    if (addr == 5'd0)      sel = 2'd0;
    else if (addr == aw_m) sel = (tn_m == 2'd0) ? 2'd2 : 2'd0;
    else if (addr == aw_w) sel = 2'd3;
    return sel;
  endfunction

  always_comb begin
    stall = need_stall(hz.tuse_rs_d, hz.a_rs_d, a_write_e_q, tnew_e_q, a_write_m_q, tnew_m_q) |
            need_stall(hz.tuse_rt_d, hz.a_rt_d, a_write_e_q, tnew_e_q, a_write_m_q, tnew_m_q);

    // A stall turns the E slot into a bubble while M and W keep draining.
    a_rs_e_d    = stall ? 5'd0 : hz.a_rs_d;
    a_rt_e_d    = stall ? 5'd0 : hz.a_rt_d;
    a_write_e_d = stall ? 5'd0 : hz.a_write_d;
    tnew_e_d    = stall ? 2'd0 : sat0(hz.tnew_d);
    a_rt_m_d    = a_rt_e_q;
    a_write_m_d = a_write_e_q;
    tnew_m_d    = sat0(tnew_e_q);
    a_write_w_d = a_write_m_q;

    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != {CNT_W{1'b1}})) stall_cnt_d = stall_cnt_q + CNT_W'(1);

    hz.stall     = stall;
    hz.fwd_rs_d  = sel_d(hz.a_rs_d, a_write_e_q, tnew_e_q, a_write_m_q, tnew_m_q, a_write_w_q);
    hz.fwd_rt_d  = sel_d(hz.a_rt_d, a_write_e_q, tnew_e_q, a_write_m_q, tnew_m_q, a_write_w_q);
    hz.fwd_rs_e  = sel_e(a_rs_e_q, a_write_m_q, tnew_m_q, a_write_w_q);
    hz.fwd_rt_e  = sel_e(a_rt_e_q, a_write_m_q, tnew_m_q, a_write_w_q);
    hz.fwd_rt_m  = (a_rt_m_q != 5'd0) && (a_rt_m_q == a_write_w_q);
    hz.stall_cnt = stall_cnt_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_rs_e_q    <= 5'd0;
      a_rt_e_q    <= 5'd0;
      a_write_e_q <= 5'd0;
      tnew_e_q    <= 2'd0;
      a_rt_m_q    <= 5'd0;
      a_write_m_q <= 5'd0;
      tnew_m_q    <= 2'd0;
      a_write_w_q <= 5'd0;
      stall_cnt_q <= '0;
    end else begin
      a_rs_e_q    <= a_rs_e_d;
      a_rt_e_q    <= a_rt_e_d;
      a_write_e_q <= a_write_e_d;
      tnew_e_q    <= tnew_e_d;
      a_rt_m_q    <= a_rt_m_d;
      a_write_m_q <= a_write_m_d;
      tnew_m_q    <= tnew_m_d;
      a_write_w_q <= a_write_w_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: a table of decode tuples with hand-derived
// stall/forward/counter values, then async-reset and counter-saturation runs.
module tb_hazard_ctrl;

  localparam int CNT_W = 4;
  localparam int NVEC  = 30;

  typedef struct {
    logic [1:0] trs, trt, tn;
    logic [4:0] ars, art, aw;
    logic       st;
    logic [1:0] frsd, frtd, frse, frte;
    logic       frtm;
    int         cnt;
  } vec_t;

  logic clk;
  logic reset_n;
  int   total;
  int   bad;
  vec_t vecs[NVEC];

  hazard_ctrl_if #(.CNT_W(CNT_W)) hz ();

  hazard_ctrl #(.CNT_W(CNT_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .hz      (hz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mkVec(input int trs, input int trt, input int tn,
                                 input int ars, input int art, input int aw,
                                 input int st, input int frsd, input int frtd,
                                 input int frse, input int frte, input int frtm,
                                 input int cnt);
    vec_t v;
    v.trs = 2'(trs);  v.trt = 2'(trt);  v.tn = 2'(tn);
    v.ars = 5'(ars);  v.art = 5'(art);  v.aw = 5'(aw);
    v.st = 1'(st);    v.frsd = 2'(frsd); v.frtd = 2'(frtd);
    v.frse = 2'(frse); v.frte = 2'(frte); v.frtm = 1'(frtm);
    v.cnt = cnt;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    hz.tuse_rs_d = v.trs;
    hz.tuse_rt_d = v.trt;
    hz.tnew_d    = v.tn;
    hz.a_rs_d    = v.ars;
    hz.a_rt_d    = v.art;
    hz.a_write_d = v.aw;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic checkAll(input string tag, input vec_t v);
    checkOutput({tag, " stall"},     32'(hz.stall),     32'(v.st));
    checkOutput({tag, " fwd_rs_d"},  32'(hz.fwd_rs_d),  32'(v.frsd));
    checkOutput({tag, " fwd_rt_d"},  32'(hz.fwd_rt_d),  32'(v.frtd));
    checkOutput({tag, " fwd_rs_e"},  32'(hz.fwd_rs_e),  32'(v.frse));
    checkOutput({tag, " fwd_rt_e"},  32'(hz.fwd_rt_e),  32'(v.frte));
    checkOutput({tag, " fwd_rt_m"},  32'(hz.fwd_rt_m),  32'(v.frtm));
    checkOutput({tag, " stall_cnt"}, 32'(hz.stall_cnt), 32'(v.cnt));
  endtask

  initial begin
    vec_t zero;
    vec_t v;
    int   nstall;
    int   expCnt;
    logic expStall;

    total = 0;
    bad   = 0;
    zero  = mkVec(3, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // trs trt tn  ars art aw | stall frsd frtd frse frte frtm cnt
    vecs[0]  = mkVec(1, 3, 3,  0,  0,  8,  0, 0, 0, 0, 0, 0, 0);  // lw $8
    vecs[1]  = mkVec(1, 1, 2,  8,  0,  9,  1, 0, 0, 0, 0, 0, 0);  // addu uses $8: stall
    vecs[2]  = mkVec(1, 1, 2,  8,  0,  9,  0, 0, 0, 0, 0, 0, 1);
    vecs[3]  = mkVec(3, 3, 0,  0,  0,  0,  0, 0, 0, 3, 0, 0, 1);  // $8 from W into E
    vecs[4]  = mkVec(1, 1, 2,  9,  0,  5,  0, 2, 0, 0, 0, 0, 1);  // addu $5 reads $9 from M
    vecs[5]  = mkVec(0, 0, 0,  5,  9,  0,  1, 0, 3, 3, 0, 0, 1);  // beq $5,$9: stall
    vecs[6]  = mkVec(0, 0, 0,  5,  9,  0,  0, 2, 0, 0, 0, 0, 2);
    vecs[7]  = mkVec(1, 1, 2,  0,  0,  5,  0, 0, 0, 3, 0, 0, 2);
    vecs[8]  = mkVec(1, 1, 2,  0,  5,  6,  0, 0, 0, 0, 0, 0, 2);  // rt=$5, tuse 1: no stall
    vecs[9]  = mkVec(1, 1, 2,  0,  0,  5,  0, 0, 0, 0, 2, 0, 2);
    vecs[10] = mkVec(3, 3, 2,  0,  0,  7,  0, 0, 0, 0, 0, 1, 2);  // store data from W
    vecs[11] = mkVec(1, 1, 2,  0,  5,  8,  0, 0, 2, 0, 0, 0, 2);
    vecs[12] = mkVec(3, 3, 0,  0,  0,  0,  0, 0, 0, 0, 3, 0, 2);
    vecs[13] = mkVec(3, 3, 3,  0,  0, 31,  0, 0, 0, 0, 0, 0, 2);  // jal
    vecs[14] = mkVec(0, 3, 0, 31,  0,  0,  1, 0, 0, 0, 0, 0, 2);  // jr $31
    vecs[15] = mkVec(0, 3, 0, 31,  0,  0,  1, 0, 0, 0, 0, 0, 3);
    vecs[16] = mkVec(0, 3, 0, 31,  0,  0,  0, 3, 0, 0, 0, 0, 4);
    vecs[17] = mkVec(1, 1, 2,  0,  0,  0,  0, 0, 0, 0, 0, 0, 4);  // write $0
    vecs[18] = mkVec(0, 0, 0,  0,  0,  0,  0, 0, 0, 0, 0, 0, 4);  // read $0
    vecs[19] = mkVec(3, 3, 3,  0,  0, 10,  0, 0, 0, 0, 0, 0, 4);
    vecs[20] = mkVec(3, 1, 0, 10, 10,  0,  1, 0, 0, 0, 0, 0, 4);  // rs not read, rt stalls
    vecs[21] = mkVec(3, 1, 0, 10, 10,  0,  0, 0, 0, 0, 0, 0, 5);
    vecs[22] = mkVec(3, 3, 0,  0,  0,  0,  0, 0, 0, 3, 3, 0, 5);
    vecs[23] = mkVec(3, 3, 1,  0,  0, 12,  0, 0, 0, 0, 0, 0, 5);
    vecs[24] = mkVec(3, 3, 1,  0,  0, 12,  0, 0, 0, 0, 0, 0, 5);
    vecs[25] = mkVec(0, 0, 0, 12, 12,  0,  0, 1, 1, 0, 0, 0, 5);  // E beats M
    vecs[26] = mkVec(3, 3, 0,  0,  0,  0,  0, 0, 0, 2, 2, 0, 5);  // M beats W
    vecs[27] = mkVec(3, 3, 1,  0,  0, 13,  0, 0, 0, 0, 0, 1, 5);
    vecs[28] = mkVec(3, 3, 2,  0,  0, 13,  0, 0, 0, 0, 0, 0, 5);
    vecs[29] = mkVec(1, 3, 0, 13,  0,  0,  0, 0, 0, 0, 0, 0, 5);  // unready E blocks ready M

    reset_n = 1'b0;
    applyStimulus(mkVec(0, 0, 3, 8, 8, 8, 0, 0, 0, 0, 0, 0, 0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkAll("reset", zero);
    @(posedge clk);
    #1 reset_n = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(vecs[i]);
      @(negedge clk);
      checkAll($sformatf("vec%0d", i), vecs[i]);
      @(posedge clk);
      #1;
    end

    // Asynchronous reset in the middle of a stall, no clock edge involved.
    applyStimulus(mkVec(3, 3, 3, 0, 0, 8, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk);
    #1 applyStimulus(mkVec(0, 0, 0, 8, 8, 0, 0, 0, 0, 0, 0, 0, 0));
    #2;
    checkOutput("pre-reset stall", 32'(hz.stall), 32'd1);
    checkOutput("pre-reset stall_cnt", 32'(hz.stall_cnt), 32'd5);
    reset_n = 1'b0;
    #1;
    checkAll("async-reset", zero);
    @(posedge clk);
    #1 reset_n = 1'b1;

    // Back-to-back lw $8 <- $8 with Tuse 0 stalls two of every three cycles.
    v = mkVec(0, 3, 3, 8, 0, 8, 0, 0, 0, 0, 0, 0, 0);
    nstall = 0;
    for (int i = 0; i < 30; i++) begin
      applyStimulus(v);
      expStall = ((i % 3) != 0);
      expCnt   = (nstall > 15) ? 15 : nstall;
      @(negedge clk);
      checkOutput($sformatf("sat%0d stall", i), 32'(hz.stall), 32'(expStall));
      checkOutput($sformatf("sat%0d stall_cnt", i), 32'(hz.stall_cnt), 32'(expCnt));
      if (expStall) nstall++;
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    checkOutput("sat final stall_cnt", 32'(hz.stall_cnt), 32'd15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
